// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter.
// Video scanout has fixed priority on the RAM port. Wishbone accesses use the
// idle RAM cycles and get a registered one-cycle ack.
// Optional macro FB_ARB_STARVE_GUARD_EN adds a starvation counter that forces a
// Wishbone grant after STARVE_LIMIT consecutive losses to scanout.
module fb_arbiter #(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       wb__adr,
  input  logic [31:0]       wb__dat_w,
  output logic [31:0]       wb__dat_r,
  input  logic [3:0]        sel,
  input  logic              wb__cyc,
  input  logic              wb__stb,
  input  logic              wb__we,
  output logic              wb__ack,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [31:0]       scan_data,
  output logic              scan_valid,
  output logic              scan_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wmask,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic              wb_req, wb_hit, wb_pend, wb_grant, scan_grant, force_wb;
  logic [ADDR_W-1:0] wb_word;
  logic [STAGES:1]   vld_pipe;
  logic              unused_ok;

  // Byte-lane bits of the address carry no information for word accesses.
  assign unused_ok = ^{wb__adr[1:0], (STARVE_LIMIT > 0)};

  // A new Wishbone request is only seen in IDLE and never in the ack cycle.
  assign wb_req   = wb__cyc && wb__stb && (state == IDLE) && !wb__ack;
  assign wb_hit   = (wb__adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign wb_word  = wb__adr[ADDR_W+1:2];
  // Grants are gated by reset so the RAM sees no access while reset is held.
  assign wb_pend    = wb_req && wb_hit && reset_n;
  assign wb_grant   = wb_pend && (!scan_req || force_wb);
  assign scan_grant = scan_req && reset_n && !wb_grant;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;

  assign force_wb = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count consecutive Wishbone losses to scanout; any Wishbone grant clears it.
  always_ff @(posedge clk) begin
    if (!reset_n)                 starve_cnt <= '0;
    else if (wb_grant)            starve_cnt <= '0;
    else if (wb_pend && scan_req) starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Flag the scanout request that was displaced by a forced grant.
  always_ff @(posedge clk) begin
    if (!reset_n) scan_stall <= 1'b0;
    else          scan_stall <= scan_req && wb_grant;
  end
`else
  assign force_wb   = 1'b0;
  assign scan_stall = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: misses ack immediately without touching the RAM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wb_req && !wb_hit) state_nxt = ACK;
        else if (wb_grant)     state_nxt = wb__we ? ACK : RD_WAIT;
      end
      RD_WAIT: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port drive, combinational from the per-cycle grant.
  always_comb begin
    ram_en    = wb_grant || scan_grant;
    ram_we    = wb_grant && wb__we;
    ram_wmask = (wb_grant && wb__we) ? sel : 4'b0000;
    ram_addr  = scan_grant ? scan_addr : wb_word;
    ram_wdata = wb__dat_w;
  end

  // Wishbone response: ack pulse on entering ACK, read data from RAM or zero on a miss.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb__ack   <= 1'b0;
      wb__dat_r <= '0;
    end else begin
      wb__ack <= (state_nxt == ACK);
      if (state == RD_WAIT)
        wb__dat_r <= ram_rdata;
      else if (wb_req && !wb_hit && !wb__we)
        wb__dat_r <= '0;
    end
  end

  // Scanout pipeline: grant -> RAM read data -> registered word with valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      scan_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], scan_grant};
      if (vld_pipe[1]) scan_data <= ram_rdata;
    end
  end

  assign scan_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for fb_arbiter with a behavioural
// synchronous-read RAM behind the arbiter's RAM port.
module tb_fb_arbiter;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       wb__adr, wb__dat_w, wb__dat_r;
  logic [3:0]        sel;
  logic              wb__cyc, wb__stb, wb__we, wb__ack;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [31:0]       scan_data;
  logic              scan_valid, scan_stall;
  logic              ram_en, ram_we;
  logic [3:0]        ram_wmask;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  bit          init_done;

  fb_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb__adr(wb__adr), .wb__dat_w(wb__dat_w), .wb__dat_r(wb__dat_r), .sel(sel),
    .wb__cyc(wb__cyc), .wb__stb(wb__stb), .wb__we(wb__we), .wb__ack(wb__ack),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data),
    .scan_valid(scan_valid), .scan_stall(scan_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: contents preset to C0DE_xxxx on the first edge, byte-masked writes.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      init_done = 1'b1;
    end
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Expected RAM word after the first masked write to word 4.
  function automatic logic [31:0] exp_word(input int i);
    return (i == 4) ? 32'hC0DE_BEEF : (32'hC0DE_0000 | i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] s);
    wb__adr = adr; wb__we = we; wb__dat_w = dat; sel = s;
    wb__cyc = 1'b1; wb__stb = 1'b1;
  endtask

  task automatic wb_drop;
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wb__adr = '0; wb__dat_w = '0; sel = '0;
    wb__cyc = 1'b0; wb__stb = 1'b0; wb__we = 1'b0;
    scan_req = 1'b1; scan_addr = 8'd9;
    step; step;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ack", 32'(wb__ack), 32'd0);
    chk("rst_dat_r", wb__dat_r, 32'd0);
    chk("rst_scan_valid", 32'(scan_valid), 32'd0);
    chk("rst_scan_data", scan_data, 32'd0);
    chk("rst_scan_stall", 32'(scan_stall), 32'd0);
    scan_req = 1'b0;
    reset_n  = 1'b1;
    step;

    // Masked write then readback of word 4.
    wb_set(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    #1;
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'd4);
    chk("wr_ram_wmask", 32'(ram_wmask), 32'h3);
    step;
    chk("wr_ack_t1", 32'(wb__ack), 32'd1);
    wb_drop;
    step;
    chk("wr_ack_gone", 32'(wb__ack), 32'd0);
    chk("wr_mem4", mem[4], 32'hC0DE_BEEF);
    wb_set(BASE + 32'h10, 1'b0, 32'h0, 4'hF);
    #1;
    chk("rd_ram_en", 32'(ram_en && !ram_we), 32'd1);
    step;
    chk("rd_ack_t1", 32'(wb__ack), 32'd0);
    step;
    chk("rd_ack_t2", 32'(wb__ack), 32'd1);
    chk("rd_dat_r", wb__dat_r, 32'hC0DE_BEEF);
    wb_drop;
    step;

    // Scanout burst of 8 back-to-back words.
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("burst_valid_%0d", c), 32'(scan_valid), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9)
        chk($sformatf("burst_data_%0d", c), scan_data, exp_word(c - 2));
      scan_req  = (c < 8);
      scan_addr = 8'(c);
      step;
    end

    // Wishbone read pending while scan_req toggles 1,0.
    scan_req = 1'b1; scan_addr = 8'd3;
    wb_set(BASE + 32'h14, 1'b0, 32'h0, 4'hF);
    #1;
    chk("tog_scan_first", 32'(ram_addr), 32'd3);
    step;
    scan_req = 1'b0;
    #1;
    chk("tog_wb_grant", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b0, 8'd5}));
    step;
    chk("tog_ack_t1", 32'(wb__ack), 32'd0);
    chk("tog_scan_valid", 32'(scan_valid), 32'd1);
    chk("tog_scan_data", scan_data, exp_word(3));
    scan_req = 1'b1; scan_addr = 8'd6;
    #1;
    chk("tog_scan_in_rdwait", 32'(ram_addr), 32'd6);
    step;
    scan_req = 1'b0;
    chk("tog_ack_t2", 32'(wb__ack), 32'd1);
    chk("tog_dat_r", wb__dat_r, exp_word(5));
    chk("tog_no_scan", 32'(scan_valid), 32'd0);
    wb_drop;
    step;
    chk("tog_scan_valid2", 32'(scan_valid), 32'd1);
    chk("tog_scan_data2", scan_data, exp_word(6));

    // Misses: read returns zero, write is dropped, RAM untouched.
    wb_set(BASE + 32'h400, 1'b0, 32'h0, 4'hF);
    #1;
    chk("miss_rd_ram_en", 32'(ram_en), 32'd0);
    step;
    chk("miss_rd_ack", 32'(wb__ack), 32'd1);
    chk("miss_rd_dat_r", wb__dat_r, 32'd0);
    wb_drop;
    #1;
    chk("miss_ack_ram_en", 32'(ram_en), 32'd0);
    step;
    wb_set(BASE + 32'h408, 1'b1, 32'hFFFF_FFFF, 4'hF);
    #1;
    chk("miss_wr_ram_en", 32'(ram_en), 32'd0);
    step;
    chk("miss_wr_ack", 32'(wb__ack), 32'd1);
    wb_drop;
    step;
    chk("miss_wr_mem2", mem[2], exp_word(2));

    // Wishbone write against continuous scanout.
    scan_req = 1'b1; scan_addr = 8'd6;
    wb_set(BASE + 32'h1C, 1'b1, 32'hA5A5_A5A5, 4'hF);
`ifdef FB_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("starve_lose_%0d", i), 32'(ram_we), 32'd0);
      step;
    end
    #1;
    chk("starve_forced", 32'({ram_we, ram_addr}), 32'({1'b1, 8'd7}));
    step;
    chk("starve_stall", 32'(scan_stall), 32'd1);
    chk("starve_ack", 32'(wb__ack), 32'd1);
    wb_drop;
    step;
    chk("starve_stall_off", 32'(scan_stall), 32'd0);
    chk("starve_no_valid", 32'(scan_valid), 32'd0);
    scan_req = 1'b0;
    step;
    chk("starve_valid_back", 32'(scan_valid), 32'd1);
    chk("starve_data_back", scan_data, exp_word(6));
    step;
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("prio_lose_%0d", i), 32'(ram_we), 32'd0);
      step;
    end
    chk("prio_no_stall", 32'(scan_stall), 32'd0);
    scan_req = 1'b0;
    #1;
    chk("prio_grant", 32'({ram_we, ram_addr}), 32'({1'b1, 8'd7}));
    step;
    chk("prio_ack", 32'(wb__ack), 32'd1);
    wb_drop;
    step; step;
`endif
    chk("wr7_mem", mem[7], 32'hA5A5_A5A5);

    // Reset during RD_WAIT aborts the read; a fresh read then works.
    wb_set(BASE + 32'h0C, 1'b0, 32'h0, 4'hF);
    step; step;
    chk("pre_rst_ack", 32'(wb__ack), 32'd1);
    chk("pre_rst_dat_r", wb__dat_r, exp_word(3));
    wb_drop;
    step;
    wb_set(BASE + 32'h08, 1'b0, 32'h0, 4'hF);
    step;
    wb_drop;
    reset_n = 1'b0; scan_req = 1'b1; scan_addr = 8'd1;
    #1;
    chk("rstrd_ram_en", 32'(ram_en), 32'd0);
    step;
    chk("rstrd_ack", 32'(wb__ack), 32'd0);
    chk("rstrd_dat_r", wb__dat_r, 32'd0);
    chk("rstrd_scan_valid", 32'(scan_valid), 32'd0);
    chk("rstrd_scan_data", scan_data, 32'd0);
    chk("rstrd_scan_stall", 32'(scan_stall), 32'd0);
    reset_n = 1'b1; scan_req = 1'b0;
    step;
    chk("rstrd_no_late_ack", 32'(wb__ack), 32'd0);
    wb_set(BASE + 32'h08, 1'b0, 32'h0, 4'hF);
    step;
    chk("fresh_ack_t1", 32'(wb__ack), 32'd0);
    step;
    chk("fresh_ack_t2", 32'(wb__ack), 32'd1);
    chk("fresh_dat_r", wb__dat_r, exp_word(2));
    wb_drop;
    step;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer RAM arbiter for the gfx demo core. Shares one synchronous-read RAM port between the Caravel Wishbone slave path (CPU pixel/register writes and readback) and the video scanout fetcher feeding the TMDS serializer. Scanout has fixed priority. Wishbone accesses fill idle RAM cycles and are acknowledged with a fixed, registered handshake.

## Interface
Parameters:
- ADDR_W, 8: RAM word-address width (2^ADDR_W 32-bit words).
- BASE_ADDR, 32'h3000_0000: Wishbone base. Must be aligned to 2^(ADDR_W+2).
- STARVE_LIMIT, 15: consecutive Wishbone losses before a forced grant (FB_ARB_STARVE_GUARD_EN only).

Ports:
- clk  in  1  system clock (wb_clk_i); all logic single-clock.
- reset_n  in  1  synchronous, active-low reset.
- wb__adr  in  32  Wishbone byte address.
- wb__dat_w  in  32  Wishbone write data.
- wb__dat_r  out  32  Wishbone read data, registered.
- sel  in  4  Wishbone byte select.
- wb__cyc, wb__stb, wb__we  in  1 each  Wishbone cycle, strobe and write enable.
- wb__ack  out  1  Wishbone ack, registered, one-cycle pulse.
- scan_req  in  1  scanout fetch request.
- scan_addr  in  ADDR_W  scanout word address.
- scan_data  out  32  fetched word, registered.
- scan_valid  out  1  scan_data valid pulse.
- scan_stall  out  1  scanout request deferred this cycle (always 0 without the macro).
- ram_en, ram_we  out  1 each  RAM enable and write enable.
- ram_wmask  out  4  byte write mask.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en && !ram_we.

## Operation
- Wishbone request: wb__cyc && wb__stb && FSM in IDLE && !wb__ack.
- Address hit: wb__adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word index is wb__adr[ADDR_W+1:2].
- Miss: acked normally, no RAM access. Write is dropped; read returns 32'h0. Guarantees no bus hang.
- Grant per cycle:
  - scan_req always wins, unless a forced grant applies (see Configuration).
  - Otherwise the pending Wishbone hit is granted.
  - Only one RAM access per cycle.
- Scanout grant: ram_en=1, ram_we=0, ram_addr=scan_addr. Fully pipelined; back-to-back requests allowed.
- Wishbone write grant: ram_en=1, ram_we=1, ram_wmask=sel, ram_wdata=wb__dat_w.
- Wishbone read grant: ram_en=1, ram_we=0.
- FSM states:
  - IDLE: grant write → ACK. Grant read → RD_WAIT. Miss → ACK, with wb__dat_r loaded 0 for reads.
  - RD_WAIT: capture ram_rdata into wb__dat_r → ACK.
  - ACK: wb__ack=1 for exactly one cycle → IDLE.
- A request that loses arbitration stays pending; inputs are held by the master per Wishbone rules.
- Dropping wb__cyc/wb__stb mid-transaction does not abort it. The ack is still issued and the master ignores it.
- Reset (reset_n=0 at a clk edge), including mid-transaction:
  - FSM → IDLE.
  - wb__ack=0, scan_valid=0, scan_stall=0, wb__dat_r=0, scan_data=0, ram_en=0, ram_we=0.
  - Starve counter cleared.
  - In-flight accesses discarded; no ack or scan_valid is produced for them.
- ram_* outputs are combinational from the grant. All other outputs are registered.

## Timing
- Scanout read: scan_req at T → ram_en at T → ram_rdata at T+1 → scan_valid=1 and scan_data registered at T+2. Fixed 2-cycle latency, throughput 1 word/cycle.
- Wishbone write, granted at T: wb__ack at T+1.
- Wishbone read, granted at T: wb__ack and wb__dat_r at T+2.
- Wishbone miss (read or write): ack at T+1.
- Earliest next Wishbone acceptance: the cycle after the ack cycle. Minimum spacing is 2 cycles for writes, 3 for reads.
- Wishbone stall while scan_req stays high: unbounded without the macro.

## Configuration
- FB_ARB_STARVE_GUARD_EN defined:
  - Counter increments each cycle a Wishbone hit is pending in IDLE and loses to scanout. Cleared on any Wishbone grant.
  - When the counter equals STARVE_LIMIT, the next pending cycle grants Wishbone even if scan_req=1.
  - That cycle, scan_stall=1 (registered, visible at T+1). No ram_en is issued for the scanout address and no scan_valid follows for it; the fetcher must re-issue.
- FB_ARB_STARVE_GUARD_EN undefined: no counter, scan_stall tied 0, strict scanout priority.

## Test plan
- Wishbone write 32'hDEADBEEF to BASE_ADDR+0x10 with sel=4'b0011, then read back → RAM word 4 low half = 16'hBEEF, upper bytes unchanged. Write ack at grant+1, read ack at grant+2 with correct data.
- scan_req held high for 8 cycles, addresses 0..7, RAM preloaded with word=index → scan_valid high 8 consecutive cycles starting 2 cycles after the first request, data 0..7 in order.
- Wishbone read pending while scan_req toggles 1,0 → read granted in the first scan_req=0 cycle, acked 2 cycles later, no scanout word lost.
- Read of BASE_ADDR+(1<<(ADDR_W+2)) (miss) → ack 1 cycle after acceptance, wb__dat_r=0, ram_en never asserted for Wishbone.
- With FB_ARB_STARVE_GUARD_EN and STARVE_LIMIT=15, scan_req held high and a Wishbone write pending → write granted after 15 losses, scan_stall=1 for one cycle, ack on the following cycle.
- reset_n=0 during RD_WAIT → next cycle wb__ack=0, wb__dat_r=0, scan_valid=0. No ack issued for the aborted read; a fresh read after reset completes normally.
